// File: rtl/wb_periph_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone peripheral arbiter:
// FSM state encoding, master indices and the default error data word.
package wb_periph_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_periph_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// master that was not granted last wins. Purely combinational.
module rr_arb2
  import wb_periph_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_grant_i == M1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/wb_periph_arbiter.sv
// Two-master Wishbone arbiter onto one peripheral slave bus: round-robin,
// one transfer per grant, bus watchdog, and a release cycle after each transfer.
module wb_periph_arbiter
  import wb_periph_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned TIMEOUT_CYC = 200,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        owner_req;
  logic        expired;
  logic        ack;
  logic        err;
  logic [31:0] rdat;

  assign req       = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign owner_req = (owner_q == M1) ? req[1] : req[0];
  assign expired   = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  rr_arb2 u_rr_arb2 (
    .req_i       (req),
    .last_grant_i(last_q),
    .gnt_o       (gnt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= M0;
      last_q  <= M1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;
    ack       = 1'b0;
    err       = 1'b0;
    rdat      = '0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req != 2'b00) begin
          owner_d = (gnt == 2'b10) ? M1 : M0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        grant_o = (owner_q == M1) ? 2'b10 : 2'b01;
        s_cyc_o = owner_req;
        s_stb_o = owner_req;
        s_we_o  = (owner_q == M1) ? m1_we_i  : m0_we_i;
        s_sel_o = (owner_q == M1) ? m1_sel_i : m0_sel_i;
        s_adr_o = (owner_q == M1) ? m1_adr_i : m0_adr_i;
        s_dat_o = (owner_q == M1) ? m1_dat_i : m0_dat_i;
        // Abort outranks ack: with the strobe down the slave's ack is not for us.
        if (!owner_req) begin
          state_d = ST_RELEASE;
        end else if (s_ack_i) begin
          ack     = 1'b1;
          rdat    = s_dat_i;
          last_d  = owner_q;
          state_d = ST_RELEASE;
        end else if (expired) begin
          err       = 1'b1;
          rdat      = ERR_DATA;
          timeout_o = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m0_ack_o = ack & (owner_q == M0);
  assign m1_ack_o = ack & (owner_q == M1);
  assign m0_err_o = err & (owner_q == M0);
  assign m1_err_o = err & (owner_q == M1);
  assign m0_dat_o = (owner_q == M0) ? rdat : '0;
  assign m1_dat_o = (owner_q == M1) ? rdat : '0;

endmodule

// File: tb/tb_wb_periph_arbiter.sv
// Self-checking bench for wb_periph_arbiter: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_wb_periph_arbiter;

  localparam int TO_CYC = 16;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = '0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current owner (-1 when none), whether the bus is in its
  // post-transfer gap, the last acked master, and BUSY cycles spent so far.
  int m_owner  = -1;
  bit m_gap    = 1'b0;
  int m_last   = 1;
  int m_waited = 0;

  wb_periph_arbiter #(
    .TIMEOUT_W  (8),
    .TIMEOUT_CYC(TO_CYC),
    .ERR_DATA   (32'hDEADBEEF)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_we_i  (m0_we_i),
    .m0_sel_i (m0_sel_i),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_sel_i (m1_sel_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so the values seen
  // at the falling edge are those the DUT registers on the coming rising edge.
  task automatic model_and_compare();
    logic [1:0]  req;
    logic        e_cyc, e_we, e_to;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_wdat;
    logic [1:0]  e_ack, e_err, e_gnt;
    logic [31:0] e_dat [2];
    int          o;
    e_cyc = 0; e_we = 0; e_to = 0; e_sel = '0; e_adr = '0; e_wdat = '0;
    e_ack = '0; e_err = '0; e_gnt = '0; e_dat[0] = '0; e_dat[1] = '0;
    req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    o = m_owner;
    if (wb_rst_i) begin
      m_owner = -1; m_gap = 1'b0; m_last = 1; m_waited = 0;
    end else if (o >= 0) begin
      e_gnt[o] = 1'b1;
      e_cyc    = req[o];
      e_we     = (o == 1) ? m1_we_i  : m0_we_i;
      e_sel    = (o == 1) ? m1_sel_i : m0_sel_i;
      e_adr    = (o == 1) ? m1_adr_i : m0_adr_i;
      e_wdat   = (o == 1) ? m1_dat_i : m0_dat_i;
      if (!req[o]) begin
        m_owner = -1; m_gap = 1'b1;
      end else if (s_ack_i) begin
        e_ack[o] = 1'b1; e_dat[o] = s_dat_i; m_last = o;
        m_owner = -1; m_gap = 1'b1;
      end else if (m_waited + 1 == TO_CYC) begin
        e_err[o] = 1'b1; e_dat[o] = 32'hDEADBEEF; e_to = 1'b1;
        m_owner = -1; m_gap = 1'b1;
      end else begin
        m_waited++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (req != 2'b00) begin
      m_owner  = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
      m_waited = 0;
    end
    check("s_cyc", s_cyc_o, e_cyc);
    check("s_stb", s_stb_o, e_cyc);
    check("s_we", s_we_o, e_we);
    check("s_sel", s_sel_o, e_sel);
    check("s_adr", s_adr_o, e_adr);
    check("s_dat", s_dat_o, e_wdat);
    check("grant", grant_o, e_gnt);
    check("timeout", timeout_o, e_to);
    check("m0_ack", m0_ack_o, e_ack[0]);
    check("m1_ack", m1_ack_o, e_ack[1]);
    check("m0_err", m0_err_o, e_err[0]);
    check("m1_err", m1_err_o, e_err[1]);
    check("m0_dat", m0_dat_o, e_dat[0]);
    check("m1_dat", m1_dat_o, e_dat[1]);
  endtask

  always @(negedge wb_clk_i) model_and_compare();

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic mid();
    #5;
  endtask

  task automatic drive_m(input int idx, input logic cyc, input logic stb, input logic we);
    if (idx == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_sel_i = 4'($urandom); m0_adr_i = $urandom; m0_dat_i = $urandom;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_sel_i = 4'($urandom); m1_adr_i = $urandom; m1_dat_i = $urandom;
    end
  endtask

  task automatic idle_all();
    drive_m(0, 0, 0, 0);
    drive_m(1, 0, 0, 0);
    s_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    wb_rst_i = 1'b1;
    step();
    step();
    wb_rst_i = 1'b0;
  endtask

  logic [1:0] rr_pat [12];
  int         mode;
  int         thr;

  initial begin
    rr_pat = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
               2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};

    // Reset value before any clock edge
    #1;
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_m0_ack", m0_ack_o, 1'b0);

    // 1: lone m0 read, slave acks two cycles after the strobe rises
    do_reset();
    drive_m(0, 1, 1, 0);
    mid();
    check("t1_idle_grant", grant_o, 2'b00);
    check("t1_idle_stb", s_stb_o, 1'b0);
    step(); mid();
    check("t1_grant", grant_o, 2'b01);
    check("t1_stb", s_stb_o, 1'b1);
    check("t1_adr", s_adr_o, m0_adr_i);
    step(); mid();
    check("t1_noack", m0_ack_o, 1'b0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'h12345678;
    mid();
    check("t1_ack", m0_ack_o, 1'b1);
    check("t1_dat", m0_dat_o, 32'h12345678);
    check("t1_m1_ack", m1_ack_o, 1'b0);
    step();
    idle_all();
    mid();
    check("t1_rel_stb", s_stb_o, 1'b0);
    check("t1_rel_grant", grant_o, 2'b00);

    // 2: both masters request continuously from reset, slave always acking
    do_reset();
    drive_m(0, 1, 1, 0);
    drive_m(1, 1, 1, 1);
    s_ack_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mid();
      check("t2_grant", grant_o, rr_pat[i]);
      check("t2_m0_ack", m0_ack_o, rr_pat[i][0]);
      check("t2_m1_ack", m1_ack_o, rr_pat[i][1]);
      step();
    end

    // 3: m1 write never acked times out; waiting m0 is granted next
    do_reset();
    drive_m(1, 1, 1, 1);
    mid();
    check("t3_idle_grant", grant_o, 2'b00);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) drive_m(0, 1, 1, 0);
      mid();
      check("t3_grant", grant_o, 2'b10);
      check("t3_ack", m1_ack_o, 1'b0);
      if (k == 15) check("t3_err_early", m1_err_o, 1'b0);
      if (k == 16) begin
        check("t3_err", m1_err_o, 1'b1);
        check("t3_timeout", timeout_o, 1'b1);
        check("t3_dat", m1_dat_o, 32'hDEADBEEF);
      end
    end
    step();
    drive_m(1, 0, 0, 0);
    mid();
    check("t3_rel_grant", grant_o, 2'b00);
    check("t3_rel_timeout", timeout_o, 1'b0);
    step(); mid();
    check("t3_idle2_grant", grant_o, 2'b00);
    step();
    s_ack_i = 1'b1;
    mid();
    check("t3_m0_grant", grant_o, 2'b01);
    check("t3_m0_ack", m0_ack_o, 1'b1);
    step();
    idle_all();

    // 4: m1 drops cyc in its third BUSY cycle
    step(); step();
    drive_m(1, 1, 1, 0);
    mid();
    check("t4_idle_grant", grant_o, 2'b00);
    step(); step(); step();
    m1_cyc_i = 1'b0;
    s_ack_i  = 1'b1;
    mid();
    check("t4_s_cyc", s_cyc_o, 1'b0);
    check("t4_grant", grant_o, 2'b10);
    check("t4_ack", m1_ack_o, 1'b0);
    check("t4_err", m1_err_o, 1'b0);
    step();
    s_ack_i = 1'b0;
    drive_m(0, 1, 1, 0);
    mid();
    check("t4_rel_grant", grant_o, 2'b00);
    step(); mid();
    check("t4_idle_grant2", grant_o, 2'b00);
    step(); mid();
    check("t4_m0_grant", grant_o, 2'b01);
    step();
    idle_all();
    step(); step();

    // 5: asynchronous reset in the middle of a BUSY cycle
    drive_m(0, 1, 1, 0);
    step(); mid();
    check("t5_busy_grant", grant_o, 2'b01);
    wb_rst_i = 1'b1;
    s_ack_i  = 1'b1;
    #1;
    check("t5_s_cyc", s_cyc_o, 1'b0);
    check("t5_s_stb", s_stb_o, 1'b0);
    check("t5_grant", grant_o, 2'b00);
    check("t5_ack", m0_ack_o, 1'b0);
    step(); step();
    wb_rst_i = 1'b0;
    s_ack_i  = 1'b0;
    drive_m(0, 1, 1, 0);
    drive_m(1, 1, 1, 0);
    mid();
    check("t5_idle_grant", grant_o, 2'b00);
    step(); mid();
    check("t5_tie_grant", grant_o, 2'b01);
    step();
    idle_all();
    step(); step();

    // 6: ack in the final watchdog cycle wins over expiry
    drive_m(0, 1, 1, 1);
    for (int k = 1; k <= TO_CYC; k++) begin
      step();
      if (k == TO_CYC) begin
        s_ack_i = 1'b1; s_dat_i = 32'hA5A5_0F0F;
      end
      mid();
      if (k == TO_CYC) begin
        check("t6_ack", m0_ack_o, 1'b1);
        check("t6_err", m0_err_o, 1'b0);
        check("t6_timeout", timeout_o, 1'b0);
        check("t6_dat", m0_dat_o, 32'hA5A5_0F0F);
      end
    end
    step();
    idle_all();
    step(); step();

    // Random traffic; mode 0 keeps the slave silent so the watchdog fires
    mode = 1;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (c % 150 == 0) mode = $urandom_range(0, 2);
      thr = (mode == 0) ? 30 : 8;
      drive_m(0, $urandom_range(0, thr) != 0, $urandom_range(0, thr) != 0, 1'($urandom));
      drive_m(1, $urandom_range(0, thr) != 0, $urandom_range(0, thr) != 0, 1'($urandom));
      s_ack_i = (mode == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      s_dat_i = $urandom;
    end
    step();
    idle_all();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
